regfile_write_ctrl: RTL

REGFILE_WRITE_CTRL -- requirements
Module: regfile_write_ctrl

---
 rtl/regfile_write_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: round-robin arbiter over three write
// requesters plus a sequenced clear of registers 1..LAST.
//
// Ports:
//   clk, rst             clock and async active-high reset
//   req_valid/req_ready  per-requester handshake (3 requesters)
//   req_dest_N/req_data_N  destination and data of requester N
//   clear_req            start a clear sequence (ignored while clearing)
//   clear_busy           high on each clear write cycle
//   clear_done           high on the final clear write
//   reg_write_*          registered write port to the register file
module regfile_write_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req_dest_0,
  input  logic [ADDR_W-1:0] req_dest_1,
  input  logic [ADDR_W-1:0] req_dest_2,
  input  logic [DATA_W-1:0] req_data_0,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state_q;
  logic [1:0]        last_grant_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              en_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;

  logic [2:0]        grant;
  logic [1:0]        gnt_idx_d;
  logic [ADDR_W-1:0] sel_dest_d;
  logic [DATA_W-1:0] sel_data_d;

  // Highest priority goes to the requester after the last one served.
  always_comb begin
    grant = 3'b000;
    if (state_q == ARB && !clear_req) begin
      unique case (last_grant_q)
        2'd0: begin
          if      (req_valid[1]) grant = 3'b010;
          else if (req_valid[2]) grant = 3'b100;
          else if (req_valid[0]) grant = 3'b001;
        end
        2'd1: begin
          if      (req_valid[2]) grant = 3'b100;
          else if (req_valid[0]) grant = 3'b001;
          else if (req_valid[1]) grant = 3'b010;
        end
        default: begin
          if      (req_valid[0]) grant = 3'b001;
          else if (req_valid[1]) grant = 3'b010;
          else if (req_valid[2]) grant = 3'b100;
        end
      endcase
    end
  end

  assign req_ready = grant;

  always_comb begin
    gnt_idx_d  = 2'd0;
    sel_dest_d = req_dest_0;
    sel_data_d = req_data_0;
    unique case (1'b1)
      grant[1]: begin
        gnt_idx_d  = 2'd1;
        sel_dest_d = req_dest_1;
        sel_data_d = req_data_1;
      end
      grant[2]: begin
        gnt_idx_d  = 2'd2;
        sel_dest_d = req_dest_2;
        sel_data_d = req_data_2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      last_grant_q <= 2'd2;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ARB: begin
          done_q <= 1'b0;
          if (clear_req) begin
            state_q <= CLEAR;
            cnt_q   <= ONE;
            en_q    <= 1'b1;
            dest_q  <= ONE;
            data_q  <= '0;
            busy_q  <= 1'b1;
          end else if (|grant) begin
            last_grant_q <= gnt_idx_d;
            en_q         <= (sel_dest_d != '0);
            dest_q       <= sel_dest_d;
            data_q       <= sel_data_d;
          end else begin
            en_q <= 1'b0;
          end
        end
        CLEAR: begin
          // cnt_q is the register written in the current cycle
          if (cnt_q == LAST) begin
            state_q <= ARB;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + ONE;
            en_q   <= 1'b1;
            dest_q <= cnt_q + ONE;
            data_q <= '0;
            busy_q <= 1'b1;
            done_q <= (cnt_q + ONE == LAST);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign clear_busy     = busy_q;
  assign clear_done     = done_q;
  assign reg_write_en   = en_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;

endmodule
